// File: rtl/led_pwm_pkg.sv
// Shared types and register map for the multi-channel LED/PMOD output port.
package led_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC    = 2'b00,
        MODE_PWM       = 2'b01,
        MODE_BLINK     = 2'b10,
        MODE_BLINK_DIM = 2'b11
    } mode_t;

    localparam logic [4:0] ADDR_LEVEL       = 5'h00;
    localparam logic [4:0] ADDR_PRESCALE_LO = 5'h01;
    localparam logic [4:0] ADDR_PRESCALE_HI = 5'h02;
    localparam logic [4:0] ADDR_MODE_BASE   = 5'h08;
    localparam logic [4:0] ADDR_DUTY_BASE   = 5'h10;

endpackage

// File: rtl/led_pwm_port_pwm_timebase.sv
// Prescaler, free-running PWM counter and blink phase shared by all channels.
module pwm_timebase #(
    parameter int PRESCALE_W = 16,
    parameter int PWM_BITS   = 8
) (
    input  logic                  clk_48mhz,
    input  logic                  reset,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  restart,
    output logic                  tick,
    output logic [PWM_BITS-1:0]   pwm_cnt,
    output logic                  wrap,
    output logic                  blink_phase
);

    logic [PRESCALE_W-1:0] pre_cnt;

    assign tick = (pre_cnt == prescale);
    assign wrap = tick && (pwm_cnt == '1);

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            pre_cnt     <= '0;
            pwm_cnt     <= '0;
            blink_phase <= 1'b0;
        end else begin
            // A new reload value always starts a fresh prescale interval
            if (restart || tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRESCALE_W'(1);
            end
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end
            if (wrap) begin
                blink_phase <= ~blink_phase;
            end
        end
    end

endmodule

// File: rtl/led_pwm_port.sv
// Register-mapped multi-channel output port: static, PWM, blink and blink-dim
// per channel, with per-pin polarity so it can drive active-low or active-high LEDs.
module led_pwm_port
    import led_pwm_pkg::*;
#(
    parameter int         CHANNELS    = 8,
    parameter int         PWM_BITS    = 8,
    parameter int         PRESCALE_W  = 16,
    parameter logic [7:0] INVERT_MASK = 8'h00
) (
    input  logic                clk_48mhz,
    input  logic                reset,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [4:0]          addr,
    input  logic [7:0]          wr_data,
    output logic [7:0]          rd_data,
    output logic [CHANNELS-1:0] port_out,
    output logic                pwm_wrap
);

    logic [CHANNELS-1:0] level_q;
    logic [15:0]         prescale_q;
    mode_t               mode_q   [CHANNELS];
    logic [PWM_BITS-1:0] shadow_q [CHANNELS];
    logic [PWM_BITS-1:0] active_q [CHANNELS];

    logic                tick_p0;
    logic                wrap_p0;
    logic                blink_phase;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [CHANNELS-1:0] v_p0;
    logic [7:0]          rd_mux;

    logic [2:0] ch_sel;
    logic       ch_ok;
    logic       is_mode;
    logic       is_duty;
    logic       wr_presc;

    assign ch_sel   = addr[2:0];
    assign ch_ok    = int'(ch_sel) < CHANNELS;
    assign is_mode  = (addr[4:3] == ADDR_MODE_BASE[4:3]);
    assign is_duty  = (addr[4:3] == ADDR_DUTY_BASE[4:3]);
    assign wr_presc = wr_en && ((addr == ADDR_PRESCALE_LO) || (addr == ADDR_PRESCALE_HI));

    // Reload register is a full 16-bit pair on the bus; only PRESCALE_W bits reach the counter
    pwm_timebase #(
        .PRESCALE_W (PRESCALE_W),
        .PWM_BITS   (PWM_BITS)
    ) u_timebase (
        .clk_48mhz   (clk_48mhz),
        .reset       (reset),
        .prescale    (prescale_q[PRESCALE_W-1:0]),
        .restart     (wr_presc),
        .tick        (tick_p0),
        .pwm_cnt     (pwm_cnt),
        .wrap        (wrap_p0),
        .blink_phase (blink_phase)
    );

    // ---- stage p0: logical channel value from mode, counters and active duty
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic pwm_hi;
        assign pwm_hi   = (pwm_cnt < active_q[ch]);
        assign v_p0[ch] = (mode_q[ch] == MODE_STATIC) ? level_q[ch] :
                          (mode_q[ch] == MODE_PWM)    ? pwm_hi      :
                          (mode_q[ch] == MODE_BLINK)  ? blink_phase :
                                                        (blink_phase & pwm_hi);
    end

    always_comb begin
        rd_mux = '0;
        if (addr == ADDR_LEVEL) begin
            rd_mux[CHANNELS-1:0] = level_q;
        end else if (addr == ADDR_PRESCALE_LO) begin
            rd_mux = prescale_q[7:0];
        end else if (addr == ADDR_PRESCALE_HI) begin
            rd_mux = prescale_q[15:8];
        end else if (is_mode && ch_ok) begin
            rd_mux = {6'b0, mode_q[ch_sel]};
        end else if (is_duty && ch_ok) begin
            rd_mux = shadow_q[ch_sel];
        end
    end

    // ---- stage p1: registers, pins and read data
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            level_q    <= '0;
            prescale_q <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                mode_q[ch]   <= MODE_STATIC;
                shadow_q[ch] <= '0;
                active_q[ch] <= '0;
            end
            port_out <= INVERT_MASK[CHANNELS-1:0];
            pwm_wrap <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr_en && (addr == ADDR_LEVEL)) begin
                level_q <= wr_data[CHANNELS-1:0];
            end
            if (wr_en && (addr == ADDR_PRESCALE_LO)) begin
                prescale_q[7:0] <= wr_data;
            end
            if (wr_en && (addr == ADDR_PRESCALE_HI)) begin
                prescale_q[15:8] <= wr_data;
            end
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (wr_en && is_mode && (ch_sel == 3'(ch))) begin
                    mode_q[ch] <= mode_t'(wr_data[1:0]);
                end
                if (wr_en && is_duty && (ch_sel == 3'(ch))) begin
                    shadow_q[ch] <= wr_data[PWM_BITS-1:0];
                end
                // A duty write on the wrap cycle bypasses the shadow into the new period
                if (tick_p0 && wrap_p0) begin
                    active_q[ch] <= (wr_en && is_duty && (ch_sel == 3'(ch)))
                                    ? wr_data[PWM_BITS-1:0] : shadow_q[ch];
                end
            end
            port_out <= v_p0 ^ INVERT_MASK[CHANNELS-1:0];
            pwm_wrap <= wrap_p0;
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule
